// File: rtl/moving_avg_var_filter.sv
// ============================================================================
// Module   : moving_avg_var_filter
// Desc     : Dual-channel SIN/COS boxcar moving average, window DELAY+1 samples,
//            history flushed on every window change.
//            Optional macro FILTER_TOP_ROUND_EN: round half-up (saturating) TOP_*.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module moving_avg_var_filter #(
   parameter int DATA_BITS     = 8,
   parameter int DELAY_BITS    = 4,
   parameter int TOP_DATA_BITS = 4
) (
   input  logic                                    CLK,
   input  logic                                    RESET_N,
   input  logic                                    CE,
   input  logic signed [DATA_BITS-1:0]             IN_SIN,
   input  logic signed [DATA_BITS-1:0]             IN_COS,
   input  logic        [DELAY_BITS-1:0]            DELAY,
   input  logic                                    DELAY_UPDATED,
   output logic signed [DATA_BITS+DELAY_BITS-1:0]  OUT_SIN,
   output logic signed [DATA_BITS+DELAY_BITS-1:0]  OUT_COS,
   output logic signed [TOP_DATA_BITS-1:0]         TOP_SIN,
   output logic signed [TOP_DATA_BITS-1:0]         TOP_COS,
   output logic                                    UPDATE,
   output logic                                    OUT_VALID
);

   localparam int                    c_acc_bits = DATA_BITS + DELAY_BITS;
   localparam int                    c_depth    = 1 << DELAY_BITS;
   localparam logic [DELAY_BITS-1:0] c_one      = {{(DELAY_BITS-1){1'b0}}, 1'b1};
   localparam logic [DELAY_BITS-1:0] c_last     = {DELAY_BITS{1'b1}};

   typedef enum logic [1:0] {
      ST_FLUSH = 2'd0,
      ST_FILL  = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   state_t                          r_state;
   logic        [DELAY_BITS-1:0]    r_cnt;
   logic        [DELAY_BITS-1:0]    r_wp;
   logic        [DELAY_BITS-1:0]    r_delay_l;
   logic signed [c_acc_bits-1:0]    r_acc_sin;
   logic signed [c_acc_bits-1:0]    r_acc_cos;
   logic                            r_update;
   logic                            r_valid;
   logic signed [DATA_BITS-1:0]     r_mem_sin [c_depth];
   logic signed [DATA_BITS-1:0]     r_mem_cos [c_depth];

   state_t                          w_state_nx;
   logic        [DELAY_BITS-1:0]    w_cnt_nx;
   logic        [DELAY_BITS-1:0]    w_wp_nx;
   logic        [DELAY_BITS-1:0]    w_delay_l_nx;
   logic signed [c_acc_bits-1:0]    w_acc_sin_nx;
   logic signed [c_acc_bits-1:0]    w_acc_cos_nx;
   logic                            w_update_nx;
   logic                            w_valid_nx;
   logic                            w_mem_we;
   logic        [DELAY_BITS-1:0]    w_mem_addr;
   logic signed [DATA_BITS-1:0]     w_mem_sin_wd;
   logic signed [DATA_BITS-1:0]     w_mem_cos_wd;
   logic        [DELAY_BITS-1:0]    w_rd;
   logic signed [c_acc_bits-1:0]    w_in_sin_ext;
   logic signed [c_acc_bits-1:0]    w_in_cos_ext;
   logic signed [c_acc_bits-1:0]    w_old_sin_ext;
   logic signed [c_acc_bits-1:0]    w_old_cos_ext;

   // Read slot is DELAY_L+1 behind the write pointer; at max window it is the
   // very slot being overwritten, whose old value is still visible this edge.
   assign w_rd          = r_wp - r_delay_l - c_one;
   assign w_in_sin_ext  = {{DELAY_BITS{IN_SIN[DATA_BITS-1]}}, IN_SIN};
   assign w_in_cos_ext  = {{DELAY_BITS{IN_COS[DATA_BITS-1]}}, IN_COS};
   assign w_old_sin_ext = {{DELAY_BITS{r_mem_sin[w_rd][DATA_BITS-1]}}, r_mem_sin[w_rd]};
   assign w_old_cos_ext = {{DELAY_BITS{r_mem_cos[w_rd][DATA_BITS-1]}}, r_mem_cos[w_rd]};

   always_comb begin
      w_state_nx   = r_state;
      w_cnt_nx     = r_cnt;
      w_wp_nx      = r_wp;
      w_delay_l_nx = r_delay_l;
      w_acc_sin_nx = r_acc_sin;
      w_acc_cos_nx = r_acc_cos;
      w_update_nx  = r_update;
      w_valid_nx   = r_valid;
      w_mem_we     = 1'b0;
      w_mem_addr   = r_wp;
      w_mem_sin_wd = IN_SIN;
      w_mem_cos_wd = IN_COS;

      if (CE) begin
         if (DELAY_UPDATED) begin
            w_state_nx   = ST_FLUSH;
            w_delay_l_nx = DELAY;
            w_cnt_nx     = '0;
            w_acc_sin_nx = '0;
            w_acc_cos_nx = '0;
            w_update_nx  = 1'b0;
            w_valid_nx   = 1'b0;
         end else begin
            case (r_state)
               ST_FLUSH: begin
                  w_mem_we     = 1'b1;
                  w_mem_addr   = r_cnt;
                  w_mem_sin_wd = '0;
                  w_mem_cos_wd = '0;
                  w_acc_sin_nx = '0;
                  w_acc_cos_nx = '0;
                  w_update_nx  = 1'b0;
                  if (r_cnt == c_last) begin
                     w_cnt_nx   = '0;
                     w_wp_nx    = '0;
                     w_state_nx = ST_FILL;
                  end else begin
                     w_cnt_nx   = r_cnt + c_one;
                  end
               end
               ST_FILL, ST_RUN: begin
                  w_mem_we     = 1'b1;
                  w_acc_sin_nx = r_acc_sin + w_in_sin_ext - w_old_sin_ext;
                  w_acc_cos_nx = r_acc_cos + w_in_cos_ext - w_old_cos_ext;
                  w_wp_nx      = r_wp + c_one;
                  if (r_cnt == r_delay_l) begin
                     w_cnt_nx    = '0;
                     w_update_nx = 1'b1;
                     w_valid_nx  = 1'b1;
                     w_state_nx  = ST_RUN;
                  end else begin
                     w_cnt_nx    = r_cnt + c_one;
                     w_update_nx = 1'b0;
                  end
               end
               default: begin
                  w_state_nx   = ST_FLUSH;
                  w_cnt_nx     = '0;
                  w_acc_sin_nx = '0;
                  w_acc_cos_nx = '0;
                  w_update_nx  = 1'b0;
                  w_valid_nx   = 1'b0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         r_state   <= ST_FLUSH;
         r_cnt     <= '0;
         r_wp      <= '0;
         r_delay_l <= DELAY;
         r_acc_sin <= '0;
         r_acc_cos <= '0;
         r_update  <= 1'b0;
         r_valid   <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_cnt     <= w_cnt_nx;
         r_wp      <= w_wp_nx;
         r_delay_l <= w_delay_l_nx;
         r_acc_sin <= w_acc_sin_nx;
         r_acc_cos <= w_acc_cos_nx;
         r_update  <= w_update_nx;
         r_valid   <= w_valid_nx;
      end
   end

   // History is never reset directly: every path into FILL passes through FLUSH.
   always_ff @(posedge CLK) begin
      if (RESET_N && w_mem_we) begin
         r_mem_sin[w_mem_addr] <= w_mem_sin_wd;
         r_mem_cos[w_mem_addr] <= w_mem_cos_wd;
      end
   end

   assign OUT_SIN   = r_acc_sin;
   assign OUT_COS   = r_acc_cos;
   assign UPDATE    = r_update;
   assign OUT_VALID = r_valid;

`ifdef FILTER_TOP_ROUND_EN
   localparam logic signed [TOP_DATA_BITS-1:0] c_top_max = {1'b0, {(TOP_DATA_BITS-1){1'b1}}};

   function automatic logic signed [TOP_DATA_BITS-1:0] top_round(
      input logic signed [c_acc_bits-1:0] acc
   );
      logic signed [TOP_DATA_BITS-1:0] trunc;
      logic                            rnd;
      trunc = acc[c_acc_bits-1 -: TOP_DATA_BITS];
      rnd   = acc[c_acc_bits-TOP_DATA_BITS-1];
      if (rnd && (trunc == c_top_max))
         return c_top_max;
      return trunc + {{(TOP_DATA_BITS-1){1'b0}}, rnd};
   endfunction

   assign TOP_SIN = top_round(r_acc_sin);
   assign TOP_COS = top_round(r_acc_cos);
`else
   assign TOP_SIN = r_acc_sin[c_acc_bits-1 -: TOP_DATA_BITS];
   assign TOP_COS = r_acc_cos[c_acc_bits-1 -: TOP_DATA_BITS];
`endif

endmodule

`default_nettype wire

// File: tb/tb_moving_avg_var_filter.sv
// ============================================================================
// Module   : tb_moving_avg_var_filter
// Desc     : Self-checking bench for moving_avg_var_filter against a sample-
//            history reference model; honours FILTER_TOP_ROUND_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_moving_avg_var_filter;

   localparam int DATA_BITS     = 8;
   localparam int DELAY_BITS    = 4;
   localparam int TOP_DATA_BITS = 4;
   localparam int c_acc_bits    = DATA_BITS + DELAY_BITS;
   localparam int c_depth       = 1 << DELAY_BITS;
   localparam int c_shift       = c_acc_bits - TOP_DATA_BITS;
   localparam int c_top_max     = (1 << (TOP_DATA_BITS - 1)) - 1;
`ifdef FILTER_TOP_ROUND_EN
   localparam int c_top_400     = 2;
`else
   localparam int c_top_400     = 1;
`endif

   logic                               CLK = 1'b0;
   logic                               RESET_N = 1'b0;
   logic                               CE = 1'b0;
   logic signed [DATA_BITS-1:0]        IN_SIN = '0;
   logic signed [DATA_BITS-1:0]        IN_COS = '0;
   logic        [DELAY_BITS-1:0]       DELAY = '0;
   logic                               DELAY_UPDATED = 1'b0;
   logic signed [c_acc_bits-1:0]       OUT_SIN;
   logic signed [c_acc_bits-1:0]       OUT_COS;
   logic signed [TOP_DATA_BITS-1:0]    TOP_SIN;
   logic signed [TOP_DATA_BITS-1:0]    TOP_COS;
   logic                               UPDATE;
   logic                               OUT_VALID;

   moving_avg_var_filter #(
      .DATA_BITS     (DATA_BITS),
      .DELAY_BITS    (DELAY_BITS),
      .TOP_DATA_BITS (TOP_DATA_BITS)
   ) dut (
      .CLK           (CLK),
      .RESET_N       (RESET_N),
      .CE            (CE),
      .IN_SIN        (IN_SIN),
      .IN_COS        (IN_COS),
      .DELAY         (DELAY),
      .DELAY_UPDATED (DELAY_UPDATED),
      .OUT_SIN       (OUT_SIN),
      .OUT_COS       (OUT_COS),
      .TOP_SIN       (TOP_SIN),
      .TOP_COS       (TOP_COS),
      .UPDATE        (UPDATE),
      .OUT_VALID     (OUT_VALID)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: samples since the last flush, trimmed to the window.
   int m_flush_left = c_depth;
   int m_win        = 1;
   int m_samples    = 0;
   bit m_upd        = 1'b0;
   int m_hs[$];
   int m_hc[$];

   task automatic check(input string tag, input logic signed [31:0] obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int exp_top(input int a);
      int r;
`ifdef FILTER_TOP_ROUND_EN
      r = (a + (1 << (c_shift - 1))) >>> c_shift;
      if (r > c_top_max) r = c_top_max;
`else
      r = a >>> c_shift;
`endif
      return r;
   endfunction

   function automatic int qsum(input bit cos_ch);
      int s = 0;
      if (cos_ch) foreach (m_hc[i]) s += m_hc[i];
      else        foreach (m_hs[i]) s += m_hs[i];
      return s;
   endfunction

   task automatic model_restart();
      m_win        = int'(DELAY) + 1;
      m_flush_left = c_depth;
      m_samples    = 0;
      m_upd        = 1'b0;
      m_hs.delete();
      m_hc.delete();
   endtask

   task automatic model_edge();
      if (!RESET_N) begin
         model_restart();
      end else if (CE) begin
         if (DELAY_UPDATED) begin
            model_restart();
         end else if (m_flush_left > 0) begin
            m_flush_left--;
            m_upd = 1'b0;
         end else begin
            m_hs.push_back(int'(IN_SIN));
            m_hc.push_back(int'(IN_COS));
            if (m_hs.size() > m_win) begin
               void'(m_hs.pop_front());
               void'(m_hc.pop_front());
            end
            m_samples++;
            m_upd = ((m_samples % m_win) == 0);
         end
      end
   endtask

   task automatic compare_all();
      check("out_sin",   OUT_SIN,   qsum(1'b0));
      check("out_cos",   OUT_COS,   qsum(1'b1));
      check("top_sin",   TOP_SIN,   exp_top(qsum(1'b0)));
      check("top_cos",   TOP_COS,   exp_top(qsum(1'b1)));
      check("update",    UPDATE,    int'(m_upd));
      check("out_valid", OUT_VALID, int'(m_samples >= m_win));
   endtask

   task automatic tick();
      @(posedge CLK);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic run_until_update(input int bound, output int cyc);
      cyc = 0;
      for (int i = 0; i < bound; i++) begin
         tick();
         cyc++;
         if (UPDATE) return;
      end
      check("update_timeout", UPDATE, 1);
   endtask

   task automatic pulse_delay_updated(input int d);
      DELAY         = DELAY_BITS'(d);
      DELAY_UPDATED = 1'b1;
      tick();
      DELAY_UPDATED = 1'b0;
      check("du_out_sin", OUT_SIN,   0);
      check("du_valid",   OUT_VALID, 0);
      check("du_update",  UPDATE,    0);
   endtask

   initial begin
      int cyc;
      int n_upd;

      // Reset with DELAY=3, constant +/-100
      RESET_N = 1'b0;
      CE      = 1'b1;
      DELAY   = 4'd3;
      IN_SIN  = 8'sd100;
      IN_COS  = -8'sd100;
      tick();
      tick();
      check("rst_out_sin", OUT_SIN,   0);
      check("rst_top_cos", TOP_COS,   0);
      check("rst_update",  UPDATE,    0);
      check("rst_valid",   OUT_VALID, 0);
      RESET_N = 1'b1;
      run_until_update(40, cyc);
      check("first_upd_latency", cyc, 20);
      check("win4_out_sin", OUT_SIN, 400);
      check("win4_out_cos", OUT_COS, -400);
      check("win4_top_sin", TOP_SIN, c_top_400);
      check("win4_top_cos", TOP_COS, -2);
      n_upd = 0;
      repeat (12) begin
         tick();
         if (UPDATE) n_upd++;
      end
      check("upd_period", n_upd, 3);

      // Step 0 -> 40 in RUN
      IN_SIN = 8'sd0;
      repeat (8) tick();
      IN_SIN = 8'sd40;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("ramp", OUT_SIN, 40 * (k + 1));
      end
      repeat (4) tick();
      check("ramp_hold", OUT_SIN, 160);

      // Window change to 8 mid-RUN
      IN_SIN = 8'sd100;
      tick();
      pulse_delay_updated(7);
      run_until_update(60, cyc);
      check("du_upd_latency", cyc, 24);
      check("win8_out_sin", OUT_SIN, 800);

      // CE gap mid-window
      repeat (3) tick();
      CE = 1'b0;
      repeat (5) begin
         IN_SIN = DATA_BITS'($urandom);
         IN_COS = DATA_BITS'($urandom);
         tick();
      end
      CE = 1'b1;
      repeat (16) begin
         IN_SIN = DATA_BITS'($urandom);
         IN_COS = DATA_BITS'($urandom);
         tick();
      end

      // Full-depth window, largest positive input
      IN_SIN = 8'sd127;
      pulse_delay_updated(15);
      run_until_update(80, cyc);
      check("win16_latency", cyc, 32);
      check("win16_out_sin", OUT_SIN, 2032);
      check("win16_top_sin", TOP_SIN, 7);

      // Reset during RUN picks up the current DELAY
      DELAY   = 4'd5;
      repeat (3) tick();
      RESET_N = 1'b0;
      tick();
      RESET_N = 1'b1;
      check("rst_run_out_sin", OUT_SIN,   0);
      check("rst_run_valid",   OUT_VALID, 0);
      run_until_update(60, cyc);
      check("rst_run_latency", cyc, 22);

      // Randomised traffic
      for (int i = 0; i < 4000; i++) begin
         CE            = ($urandom % 8) != 0;
         IN_SIN        = DATA_BITS'($urandom);
         IN_COS        = DATA_BITS'($urandom);
         DELAY_UPDATED = ($urandom % 64) == 0;
         if (($urandom % 16) == 0) DELAY = DELAY_BITS'($urandom);
         RESET_N       = ($urandom % 700) != 0;
         tick();
      end
      DELAY_UPDATED = 1'b0;
      RESET_N       = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/moving_avg_var_filter.md
# moving_avg_var_filter

Dual-channel (SIN/COS) boxcar moving-average filter with a runtime-variable window of DELAY+1 samples, built as a circular delay line plus running-sum accumulators. It sits directly upstream of filter_autoscale_control: it supplies TOP_SIN/TOP_COS and the UPDATE strobe, and it takes back DELAY/DELAY_UPDATED. On every window change it flushes its history, so the output never mixes two window lengths.

## Interface
- DATA_BITS, 8: signed input sample width per channel.
- DELAY_BITS, 4: window control width; delay line depth 2^DELAY_BITS; max window 2^DELAY_BITS samples.
- TOP_DATA_BITS, 4: width of the TOP_* outputs fed to autoscale control.
- CLK  in  1  single clock; all logic is rising-edge.
- RESET_N  in  1  synchronous, active-low reset.
- CE  in  1  sample enable; state advances only on CLK edges with CE=1 (except reset).
- IN_SIN, IN_COS  in  DATA_BITS  signed input samples, consumed when CE=1.
- DELAY  in  DELAY_BITS  window length minus one, from autoscale control.
- DELAY_UPDATED  in  1  one CE-cycle pulse; DELAY has changed.
- OUT_SIN, OUT_COS  out  DATA_BITS+DELAY_BITS  signed running sums over the window.
- TOP_SIN, TOP_COS  out  TOP_DATA_BITS  signed top bits of OUT_*.
- UPDATE  out  1  one CE-cycle pulse per completed window.
- OUT_VALID  out  1  high when the window is full (state RUN).

## Operation
- ACC_BITS = DATA_BITS+DELAY_BITS. Sign-extend input to ACC_BITS, then acc <= acc + in - mem[rd]; mem[wp] <= in. rd = (wp - DELAY_L - 1) mod 2^DELAY_BITS. Read happens before write, so DELAY_L = max reads the slot being overwritten. Arithmetic is exact: no overflow is possible.
- DELAY_L holds DELAY latched at entry to FLUSH. DELAY changes without DELAY_UPDATED are ignored.
- States:
  - FLUSH: writes 0 to mem[cnt] for cnt = 0..2^DELAY_BITS-1 (one entry per CE cycle). acc=0, inputs ignored. After the last entry: wp=0, cnt=0, go to FILL.
  - FILL: accumulates inputs. cnt counts 0..DELAY_L. When a sample is processed with cnt==DELAY_L: cnt=0, UPDATE=1, go to RUN.
  - RUN: same datapath. cnt wraps at DELAY_L, and each wrap pulses UPDATE.
- DELAY_UPDATED=1 with CE=1 in any state: latch DELAY, clear acc and cnt, enter FLUSH. This has priority over sample processing in that cycle.
- TOP_* = acc[ACC_BITS-1 -: TOP_DATA_BITS] (truncation, i.e. floor), unless the macro in Configuration is defined.
- Reset (RESET_N=0 at a CLK edge, regardless of CE):
  - state=FLUSH, cnt=0, wp=0, DELAY_L=DELAY.
  - OUT_*=0, TOP_*=0, UPDATE=0, OUT_VALID=0.

## Timing
- The accumulator is the output register: OUT_* reflect a sample at the CE edge that consumes it (latency 1 CLK).
- UPDATE is registered at the same edge as the window-completing sum and stays high until the next CE edge, so OUT_*/TOP_* are stable while UPDATE=1.
- OUT_VALID=1 from the edge that enters RUN. It drops at the edge that enters FLUSH.
- Time from DELAY_UPDATED to first UPDATE: 2^DELAY_BITS + DELAY+1 CE cycles.
- CE=0: all registers hold, including UPDATE.
- Simultaneous events:
  - DELAY_UPDATED during FLUSH restarts the flush counter.
  - DELAY_UPDATED on a window-completing cycle suppresses that UPDATE.
  - RESET_N overrides everything.

## Configuration
- FILTER_TOP_ROUND_EN defined: TOP_* are rounded half-up. The top slice gets +1 if acc[ACC_BITS-TOP_DATA_BITS-1]=1, and the result saturates at the max positive value (never wraps). Still combinational from acc, same timing.
- Not defined: plain truncation as above.

## Test plan
All scenarios use defaults: DATA_BITS=8, DELAY_BITS=4, TOP_DATA_BITS=4, CE=1.
- Reset, then DELAY=3 and constant IN_SIN=100, IN_COS=-100:
  - OUT_VALID=0 for 16 flush + 3 fill cycles; first UPDATE 20 cycles after reset release.
  - OUT_SIN=400, OUT_COS=-400, TOP_SIN=1 (2 with FILTER_TOP_ROUND_EN), TOP_COS=-2.
  - UPDATE repeats every 4 cycles.
- DELAY=15, IN_SIN=127:
  - OUT_SIN=2032, TOP_SIN=7.
  - With the macro, TOP_SIN=7 (saturated, not -8).
- Step IN_SIN from 0 to 40 in RUN with DELAY=3: OUT_SIN ramps 40, 80, 120, 160 over 4 cycles, then holds.
- Pulse DELAY_UPDATED with DELAY=7 mid-RUN:
  - Next edge: OUT_*=0, OUT_VALID=0, UPDATE=0.
  - First UPDATE 24 CE cycles later, OUT_SIN=800 for input 100.
- Toggle CE=0 for 5 cycles mid-window: outputs and UPDATE held, cnt unchanged; counting resumes exactly when CE returns to 1.
- RESET_N=0 for one edge during RUN: all outputs 0 the next cycle; the full flush sequence restarts using the current DELAY.
